// File: rtl/xb_mem8_pkg.sv
// Shared definitions for the mem_8 register bank controller: default widths,
// the read-side state encoding and the index of the LED register.
package xb_mem8_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Read-side control states
    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        FLUSH  = 2'd1,
        RUN    = 2'd2
    } state_e;

    // Bank word whose low nibble drives the board LEDs
    localparam int LED_REG = 0;

endpackage

// File: rtl/xb_prefetch_buf.sv
// Two-entry first-word-fall-through buffer sitting between the registered
// bank read and the host read port. Entry 0 is always the head.
module xb_prefetch_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop_i & (count_q != 2'd0);
    assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

    // Next contents: a flush empties the buffer, otherwise shift on pop and fill the first free slot on push
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
            if (push_i) begin
                ent0_d  = push_data_i;
                count_d = 2'd1;
            end
        end else begin
            case ({push_ok, pop_ok})
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = push_data_i;
                    end else begin
                        ent1_d = push_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Buffer storage and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = ent0_q;
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/xb_mem8_regbank_ctrl.sv
// Seekable mem_8 user-port controller: a DEPTH x DATA_W register bank with a
// write pointer, a read pointer served through a 2-entry prefetch buffer, and
// a fetch pointer that runs ahead of the read pointer.
// Optional feature macro: XB_MEM8_EOF_EN (stop fetching at the last word and
// raise eof once it has been popped).
module xb_mem8_regbank_ctrl
    import xb_mem8_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic              quiesce,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    input  logic              user_w_mem_8_open,
    input  logic              user_w_mem_8_wren,
    input  logic [DATA_W-1:0] user_w_mem_8_data,
    output logic              user_w_mem_8_full,
    input  logic              user_r_mem_8_open,
    input  logic              user_r_mem_8_rden,
    output logic [DATA_W-1:0] user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    output logic [3:0]        gpio_led
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LED_IDX = ADDR_W'(LED_REG);

    logic [DATA_W-1:0] bank_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] fptr_q, fptr_d;
    state_e            state_q, state_d;

    logic              seek;
    logic              wr_acc;
    logic              pop;
    logic              flush_buf;
    logic              fetch_room;
    logic              fetch_blocked;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic [1:0]        buf_count;
    logic              buf_empty;

    assign user_w_mem_8_full = quiesce | ~user_w_mem_8_open;
    assign seek              = user_mem_8_addr_update;
    assign wr_acc            = user_w_mem_8_wren & ~user_w_mem_8_full;
    assign pop               = user_r_mem_8_rden & ~buf_empty;

    // Anything that can make buffered words stale empties the buffer; a closed port holds it empty
    assign flush_buf = seek | wr_acc | quiesce | ~user_r_mem_8_open | (state_q == CLOSED);

    // The FLUSH cycle restarts fetching from the read pointer; RUN continues from the fetch pointer
    assign fetch_addr = (state_q == FLUSH) ? rptr_q : fptr_q;
    assign fetch_room = (state_q == FLUSH) | ((state_q == RUN) & (buf_count < 2'd2));
    assign fetch      = ~flush_buf & fetch_room & ~fetch_blocked;

`ifdef XB_MEM8_EOF_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic fetch_done_q, fetch_done_d;
    logic eof_q, eof_d;

    // Remember that the last word has been fetched, and flag eof once it has been popped
    always_comb begin
        fetch_done_d = fetch_done_q;
        eof_d        = eof_q;
        if (flush_buf) begin
            fetch_done_d = 1'b0;
            eof_d        = 1'b0;
        end else begin
            if (fetch && (fetch_addr == LAST_ADDR)) begin
                fetch_done_d = 1'b1;
            end
            if (pop && (rptr_q == LAST_ADDR)) begin
                eof_d = 1'b1;
            end
        end
    end

    // End-of-space tracking registers
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            fetch_done_q <= 1'b0;
            eof_q        <= 1'b0;
        end else begin
            fetch_done_q <= fetch_done_d;
            eof_q        <= eof_d;
        end
    end

    assign fetch_blocked    = fetch_done_q;
    assign user_r_mem_8_eof = eof_q;
`else
    assign fetch_blocked    = 1'b0;
    assign user_r_mem_8_eof = 1'b0;
`endif

    // Pointer updates in priority order: pop and write advance, flush realigns fetch, seek overrides all
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        fptr_d = fptr_q;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (wr_acc) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (flush_buf) begin
            fptr_d = rptr_d;
        end else if (fetch) begin
            fptr_d = fetch_addr + 1'b1;
        end
        if (seek) begin
            rptr_d = user_mem_8_addr;
            wptr_d = user_mem_8_addr;
            fptr_d = user_mem_8_addr;
        end
    end

    // Read-side state: closing wins, any flush cause holds FLUSH for a cycle, otherwise RUN
    always_comb begin
        state_d = state_q;
        if (!user_r_mem_8_open) begin
            state_d = CLOSED;
        end else begin
            case (state_q)
                CLOSED:      state_d = FLUSH;
                FLUSH, RUN:  state_d = (seek | wr_acc | quiesce) ? FLUSH : RUN;
                default:     state_d = CLOSED;
            endcase
        end
    end

    // Pointer and state registers
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fptr_q  <= '0;
            state_q <= CLOSED;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fptr_q  <= fptr_d;
            state_q <= state_d;
        end
    end

    // Register bank; a write lands at the pointer value from before any same-cycle seek
    always_ff @(posedge bus_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_acc) begin
            bank_q[wptr_q] <= user_w_mem_8_data;
        end
    end

    xb_prefetch_buf #(
        .DATA_W (DATA_W)
    ) u_prefetch (
        .clk_i       (bus_clk),
        .rst_ni      (trn_reset_n),
        .flush_i     (flush_buf),
        .push_i      (fetch),
        .push_data_i (bank_q[fetch_addr]),
        .pop_i       (pop),
        .head_o      (user_r_mem_8_data),
        .count_o     (buf_count),
        .empty_o     (buf_empty)
    );

    assign user_r_mem_8_empty = buf_empty;
    assign gpio_led           = bank_q[LED_IDX][3:0];

endmodule
